pow_est_strobe: RTL and testbench

- Upstream stage of peak_detect_nrx: feeds its pow_in and peak_stb_in.
- Takes a complex I/Q AXI-stream and computes instantaneous power I²+Q², scaled to POW_WIDTH bits.
- Smooths the power with a 2^AVG_LOG2-sample moving average.
- Emits a one-beat peak strobe on a rising threshold crossing, with holdoff and hysteresis re-arm.
- The I/Q payload passes through, delay-matched to the power and strobe.

---
 rtl/pow_est_pkg.sv | 24 ++
 rtl/pow_est_strobe_moving_sum.sv | 52 +++++
 rtl/pow_est_strobe.sv | 189 ++++++++++++++++++
 tb/tb_pow_est_strobe.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pow_est_pkg.sv
// Shared defaults, window sizing and strobe FSM states for the I/Q power
// estimator that feeds the peak detector.
package pow_est_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_POW_WIDTH  = 16;
  localparam int DEF_AVG_LOG2   = 4;
  localparam int DEF_HOLDOFF    = 64;

  localparam int WIN   = 1 << DEF_AVG_LOG2;
  localparam int SUM_W = DEF_POW_WIDTH + DEF_AVG_LOG2;

  // ST_ prefix keeps the labels clear of the HOLDOFF parameter name
  typedef enum logic [1:0] {
    ST_ARMED,
    ST_HOLDOFF,
    ST_WAIT_LOW
  } stb_state_e;

  function automatic int win_of(input int avg_log2);
    return 1 << avg_log2;
  endfunction

endpackage

// File: rtl/pow_est_strobe_moving_sum.sv
// Moving average over the last 2^AVG_LOG2 power samples: circular delay line
// plus running sum. dout_avg/full describe the window including din.
module moving_sum
  import pow_est_pkg::*;
#(
  parameter int W        = DEF_POW_WIDTH,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout_avg,
  output logic         full
);

  localparam int DEPTH  = win_of(AVG_LOG2);
  localparam int ACC_W  = W + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;

  logic [W-1:0]        dline [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [ACC_W-1:0]    sum_q;
  logic [ACC_W-1:0]    sum_d;
  logic [FILL_W-1:0]   fill;

  // unwritten slots are zero, so the oldest entry of a partial window adds nothing
  assign sum_d    = sum_q + ACC_W'(din) - ACC_W'(dline[wr_ptr]);
  assign dout_avg = sum_d[ACC_W-1:AVG_LOG2];
  assign full     = (fill >= FILL_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) dline[k] <= '0;
      wr_ptr <= '0;
      sum_q  <= '0;
      fill   <= '0;
    end else if (clear) begin
      for (int k = 0; k < DEPTH; k++) dline[k] <= '0;
      wr_ptr <= '0;
      sum_q  <= '0;
      fill   <= '0;
    end else if (en) begin
      dline[wr_ptr] <= din;
      wr_ptr        <= wr_ptr + AVG_LOG2'(1);
      sum_q         <= sum_d;
      if (fill != FILL_W'(DEPTH)) fill <= fill + FILL_W'(1);
    end
  end

endmodule

// File: rtl/pow_est_strobe.sv
// I/Q power estimator: square, sum/scale, moving average and a threshold
// strobe with holdoff and hysteresis, delay-matched to the I/Q pass-through.
module pow_est_strobe
  import pow_est_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int POW_WIDTH  = DEF_POW_WIDTH,
  parameter int AVG_LOG2   = DEF_AVG_LOG2,
  parameter int HOLDOFF    = DEF_HOLDOFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [POW_WIDTH-1:0]    thresh_hi,
  input  logic [POW_WIDTH-1:0]    thresh_lo,
  input  logic [2*DATA_WIDTH-1:0] in_tdata,
  input  logic                    in_tvalid,
  input  logic                    in_tlast,
  output logic                    in_tready,
  output logic [2*DATA_WIDTH-1:0] out_tdata,
  output logic                    out_tvalid,
  output logic                    out_tlast,
  input  logic                    out_tready,
  output logic [POW_WIDTH-1:0]    pow_out,
  output logic                    peak_stb_out
);

  localparam int DW   = DATA_WIDTH;
  localparam int MW   = 2 * DATA_WIDTH;
  localparam int HC_W = $clog2(HOLDOFF + 1);
  localparam logic [MW-1:0] P_MAX = MW'((64'd1 << POW_WIDTH) - 64'd1);

  logic en;
  assign en        = out_tready | ~out_tvalid;
  assign in_tready = en & ~clear;

  logic signed [DW-1:0] in_i;
  logic signed [DW-1:0] in_q;
  assign in_i = in_tdata[MW-1:DW];
  assign in_q = in_tdata[DW-1:0];

  logic                 s1_valid;
  logic                 s1_last;
  logic [MW-1:0]        s1_data;
  logic signed [MW-1:0] s1_i2;
  logic signed [MW-1:0] s1_q2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
      s1_i2    <= '0;
      s1_q2    <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
      s1_i2    <= '0;
      s1_q2    <= '0;
    end else if (en) begin
      s1_valid <= in_tvalid;
      s1_last  <= in_tlast;
      s1_data  <= in_tdata;
      s1_i2    <= MW'(in_i) * MW'(in_i);
      s1_q2    <= MW'(in_q) * MW'(in_q);
    end
  end

  // both squares are non-negative, so their sum fits MW bits unsigned
  logic [MW-1:0]        mag;
  logic [MW-1:0]        p_wide;
  logic [POW_WIDTH-1:0] p_sat;
  assign mag    = $unsigned(s1_i2) + $unsigned(s1_q2);
  assign p_wide = mag >> DW;
  assign p_sat  = (p_wide > P_MAX) ? P_MAX[POW_WIDTH-1:0] : p_wide[POW_WIDTH-1:0];

  logic                 s2_valid;
  logic                 s2_last;
  logic [MW-1:0]        s2_data;
  logic [POW_WIDTH-1:0] s2_p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_data  <= '0;
      s2_p     <= '0;
    end else if (clear) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_data  <= '0;
      s2_p     <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_data  <= s1_data;
      s2_p     <= p_sat;
    end
  end

  logic                 adv;
  logic [POW_WIDTH-1:0] ms_avg;
  logic                 ms_full;
  assign adv = en & s2_valid;

  moving_sum #(
    .W        (POW_WIDTH),
    .AVG_LOG2 (AVG_LOG2)
  ) u_moving_sum (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .en       (adv),
    .din      (s2_p),
    .dout_avg (ms_avg),
    .full     (ms_full)
  );

  stb_state_e      state_q;
  stb_state_e      state_d;
  logic [HC_W-1:0] hcnt_q;
  logic [HC_W-1:0] hcnt_d;
  logic            fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ARMED;
      hcnt_q  <= '0;
    end else if (clear) begin
      state_q <= ST_ARMED;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // the FSM only moves on beats entering the output stage
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    fire    = 1'b0;
    if (adv) begin
      case (state_q)
        ST_ARMED: begin
          if (ms_full && (ms_avg > thresh_hi)) begin
            fire    = 1'b1;
            state_d = ST_HOLDOFF;
            hcnt_d  = '0;
          end
        end
        ST_HOLDOFF: begin
          if (hcnt_q == HC_W'(HOLDOFF - 1)) state_d = ST_WAIT_LOW;
          else                              hcnt_d  = hcnt_q + HC_W'(1);
        end
        ST_WAIT_LOW: begin
          if (ms_avg <= thresh_lo) state_d = ST_ARMED;
        end
        default: state_d = ST_ARMED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_tvalid   <= 1'b0;
      out_tlast    <= 1'b0;
      out_tdata    <= '0;
      pow_out      <= '0;
      peak_stb_out <= 1'b0;
    end else if (clear) begin
      out_tvalid   <= 1'b0;
      out_tlast    <= 1'b0;
      out_tdata    <= '0;
      pow_out      <= '0;
      peak_stb_out <= 1'b0;
    end else if (en) begin
      out_tvalid   <= s2_valid;
      peak_stb_out <= fire;
      if (s2_valid) begin
        out_tdata <= s2_data;
        out_tlast <= s2_last;
        pow_out   <= ms_avg;
      end
    end
  end

endmodule

// File: tb/tb_pow_est_strobe.sv
// Self-checking bench for pow_est_strobe: randomized stimulus scored against a
// window/threshold model of expected output beats, plus pinned literal values.
module tb_pow_est_strobe;

  localparam int DW   = 16;
  localparam int PW   = 16;
  localparam int AL   = 4;
  localparam int HO   = 64;
  localparam int WINB = 1 << AL;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [PW-1:0] thresh_hi;
  logic [PW-1:0] thresh_lo;
  logic [31:0]   in_tdata;
  logic          in_tvalid;
  logic          in_tlast;
  logic          in_tready;
  logic [31:0]   out_tdata;
  logic          out_tvalid;
  logic          out_tlast;
  logic          out_tready;
  logic [PW-1:0] pow_out;
  logic          peak_stb_out;

  always #5 clk = ~clk;

  pow_est_strobe #(
    .DATA_WIDTH (DW),
    .POW_WIDTH  (PW),
    .AVG_LOG2   (AL),
    .HOLDOFF    (HO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .thresh_hi    (thresh_hi),
    .thresh_lo    (thresh_lo),
    .in_tdata     (in_tdata),
    .in_tvalid    (in_tvalid),
    .in_tlast     (in_tlast),
    .in_tready    (in_tready),
    .out_tdata    (out_tdata),
    .out_tvalid   (out_tvalid),
    .out_tlast    (out_tlast),
    .out_tready   (out_tready),
    .pow_out      (pow_out),
    .peak_stb_out (peak_stb_out)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          pow;
    logic        stb;
  } beat_t;

  beat_t exp_q[$];
  int    win_q[$];
  int    since_fire;
  bit    need_low;
  int    obs_pow[$];
  bit    obs_stb[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    first_acc = -1;
  int    first_out = -1;
  bit    tready_rand = 1'b0;
  int    tready_pct = 100;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic void modelReset();
    exp_q.delete();
    win_q.delete();
    since_fire = 0;
    need_low   = 1'b0;
  endfunction

  // expected output beat: floor of the last-16 power sum over 16, missing slots as zero
  function automatic void modelAccept(input logic [31:0] d, input logic l);
    logic signed [15:0] iv;
    logic signed [15:0] qv;
    longint ii, qq, p, sum;
    int     avg;
    bit     full;
    beat_t  b;
    iv = d[31:16];
    qv = d[15:0];
    ii = iv;
    qq = qv;
    p  = (ii * ii + qq * qq) >> DW;
    if (p > (1 << PW) - 1) p = (1 << PW) - 1;
    win_q.push_back(int'(p));
    if (win_q.size() > WINB) void'(win_q.pop_front());
    sum = 0;
    foreach (win_q[k]) sum += win_q[k];
    avg  = int'(sum / WINB);
    full = (win_q.size() == WINB);
    b.stb = 1'b0;
    if (need_low) begin
      since_fire++;
      if (since_fire > HO && avg <= int'(thresh_lo)) need_low = 1'b0;
    end else if (full && avg > int'(thresh_hi)) begin
      b.stb      = 1'b1;
      need_low   = 1'b1;
      since_fire = 0;
    end
    b.data = d;
    b.last = l;
    b.pow  = avg;
    exp_q.push_back(b);
  endfunction

  function automatic int countStb();
    int n = 0;
    foreach (obs_stb[k]) n += int'(obs_stb[k]);
    return n;
  endfunction

  function automatic int obsPow(input int i);
    return (i < obs_pow.size()) ? obs_pow[i] : -1;
  endfunction

  function automatic int obsStb(input int i);
    return (i < obs_stb.size()) ? int'(obs_stb[i]) : -1;
  endfunction

  // compare process: scores every output handshake and checks stall stability
  initial begin : monitor
    beat_t       e;
    logic [31:0] pd;
    logic [15:0] pp;
    logic        pl, ps;
    bit          prev_stall;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        modelReset();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checkOutput("hold_valid", out_tvalid, 1);
          checkOutput("hold_data", out_tdata, pd);
          checkOutput("hold_last", out_tlast, pl);
          checkOutput("hold_pow", pow_out, pp);
          checkOutput("hold_stb", peak_stb_out, ps);
        end
        if (out_tvalid && first_out < 0) first_out = cyc;
        if (out_tvalid && out_tready) begin
          checkOutput("beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("out_tdata", out_tdata, e.data);
            checkOutput("out_tlast", out_tlast, e.last);
            checkOutput("pow_out", pow_out, e.pow);
            checkOutput("peak_stb_out", peak_stb_out, e.stb);
          end
          obs_pow.push_back(int'(pow_out));
          obs_stb.push_back(peak_stb_out);
        end
        if (in_tvalid && in_tready) begin
          if (first_acc < 0) first_acc = cyc;
          modelAccept(in_tdata, in_tlast);
        end
        if (clear) modelReset();
        prev_stall = out_tvalid && !out_tready && !clear;
        pd = out_tdata;
        pl = out_tlast;
        pp = pow_out;
        ps = peak_stb_out;
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (tready_rand) out_tready = ($urandom_range(0, 99) < tready_pct);
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic l, input int gap_pct);
    int guard;
    bit acc;
    guard = 0;
    acc   = 1'b0;
    for (int g = 0; g < 4 && ($urandom_range(0, 99) < gap_pct); g++) stepCycle();
    in_tdata  = d;
    in_tlast  = l;
    in_tvalid = 1'b1;
    while (!acc && guard < 1000) begin
      @(negedge clk);
      acc = in_tready;
      stepCycle();
      guard++;
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    if (!acc) checkOutput("accept_timeout", guard, 0);
  endtask

  task automatic drain();
    tready_rand = 1'b0;
    out_tready  = 1'b1;
    for (int g = 0; g < 200 && exp_q.size() != 0; g++) stepCycle();
    checkOutput("drain_empty", exp_q.size(), 0);
  endtask

  task automatic doClear(input logic [31:0] d);
    clear     = 1'b1;
    in_tvalid = 1'b1;
    in_tdata  = d;
    #1;
    checkOutput("clear_tready", in_tready, 0);
    stepCycle();
    clear     = 1'b0;
    in_tvalid = 1'b0;
    checkOutput("clear_valid", out_tvalid, 0);
    checkOutput("clear_pow", pow_out, 0);
    checkOutput("clear_stb", peak_stb_out, 0);
    checkOutput("clear_data", out_tdata, 0);
    checkOutput("clear_last", out_tlast, 0);
  endtask

  task automatic resetObs();
    obs_pow.delete();
    obs_stb.delete();
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin : stimulus
    logic [31:0] d;
    reset      = 1'b0;
    clear      = 1'b0;
    in_tvalid  = 1'b0;
    in_tlast   = 1'b0;
    in_tdata   = '0;
    out_tready = 1'b1;
    thresh_hi  = 16'd100;
    thresh_lo  = 16'd50;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", out_tvalid, 0);
    checkOutput("rst_pow", pow_out, 0);
    checkOutput("rst_stb", peak_stb_out, 0);
    checkOutput("rst_data", out_tdata, 0);
    checkOutput("rst_last", out_tlast, 0);
    #2 reset = 1'b1;
    stepCycle();

    $display("[TB] zero input, latency");
    resetObs();
    first_acc = -1;
    first_out = -1;
    repeat (100) applyStimulus(32'h0, 1'b0, 0);
    drain();
    checkOutput("t1_latency", first_out - first_acc, 3);
    checkOutput("t1_strobes", countStb(), 0);
    checkOutput("t1_beats", obs_pow.size(), 100);

    $display("[TB] constant ramp, drop, re-arm");
    thresh_hi = 16'd3000;
    thresh_lo = 16'd1000;
    doClear(32'h1234_5678);
    resetObs();
    tready_rand = 1'b1;
    tready_pct  = 75;
    for (int k = 0; k < 400; k++) begin
      d = (k < 200 || k >= 300) ? 32'h4000_0000 : 32'h0;
      applyStimulus(d, (k % 50) == 49, 20);
    end
    drain();
    checkOutput("t2_avg_beat1", obsPow(0), 256);
    checkOutput("t2_avg_beat12", obsPow(11), 3072);
    checkOutput("t2_nostb_beat12", obsStb(11), 0);
    checkOutput("t2_avg_beat16", obsPow(15), 4096);
    checkOutput("t2_stb_beat16", obsStb(15), 1);
    checkOutput("t3_stb_beat312", obsStb(311), 1);
    checkOutput("t3_avg_beat312", obsPow(311), 3072);
    checkOutput("t3_strobes", countStb(), 2);

    $display("[TB] toggling input against holdoff");
    thresh_hi = 16'd1500;
    thresh_lo = 16'd2048;
    doClear(32'h0);
    resetObs();
    tready_rand = 1'b1;
    tready_pct  = 75;
    for (int k = 0; k < 120; k++) begin
      d = (((k / 8) % 2) == 0) ? 32'h4000_0000 : 32'h0;
      applyStimulus(d, 1'b0, 10);
    end
    drain();
    checkOutput("t4_stb_first", obsStb(15), 1);
    checkOutput("t4_stb_second", obsStb(81), 1);
    checkOutput("t4_strobes", countStb(), 2);

    $display("[TB] full-scale negative I/Q");
    thresh_hi = 16'hFFFF;
    thresh_lo = 16'd0;
    doClear(32'h0);
    resetObs();
    for (int k = 0; k < 30; k++) applyStimulus(32'h8000_8000, 1'b0, 0);
    drain();
    checkOutput("t5_avg_beat1", obsPow(0), 2048);
    checkOutput("t5_avg_full", obsPow(15), 32768);
    checkOutput("t5_avg_last", obsPow(29), 32768);
    checkOutput("t5_strobes", countStb(), 0);

    $display("[TB] random backpressure with mid-stream clear");
    thresh_hi = 16'd2000;
    thresh_lo = 16'd500;
    doClear(32'h0);
    resetObs();
    tready_rand = 1'b1;
    tready_pct  = 50;
    for (int k = 0; k < 300; k++) begin
      if (k == 150) doClear($urandom);
      d[31:16] = 16'(k * 100);
      d[15:0]  = 16'($urandom_range(0, 65535));
      applyStimulus(d, $urandom_range(0, 15) == 0, 30);
    end
    drain();

    $display("[TB] async reset during stall");
    thresh_hi = 16'd3000;
    thresh_lo = 16'd1000;
    doClear(32'h0);
    tready_rand = 1'b0;
    out_tready  = 1'b0;
    repeat (3) applyStimulus(32'h4000_0000, 1'b0, 0);
    stepCycle();
    stepCycle();
    checkOutput("stall_valid", out_tvalid, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_valid", out_tvalid, 0);
    checkOutput("arst_pow", pow_out, 0);
    checkOutput("arst_data", out_tdata, 0);
    checkOutput("arst_stb", peak_stb_out, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    stepCycle();
    out_tready = 1'b1;
    resetObs();
    repeat (20) applyStimulus(32'h4000_0000, 1'b0, 0);
    drain();
    checkOutput("t7_avg_restart", obsPow(0), 256);
    checkOutput("t7_beats", obs_pow.size(), 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
